status_cond_unit: RTL

Execute-stage status register and condition evaluator for the five-stage ARM pipeline. The block consumes the ALU's 4-bit status vector, commits N/Z/C/V when a flag-setting instruction leaves EX, and returns the committed carry to the ALU for ADC/SBC. It evaluates the ID-stage instruction's condition field against the flags, bypassing any in-flight EX update, and registers the pass/fail result into the ID/EX boundary.

---
 rtl/arm_pkg.sv | 41 ++++
 rtl/cond_check.sv | 39 +++
 rtl/status_cond_unit.sv | 75 +++++++
 3 files changed

// File: rtl/arm_pkg.sv
// Shared ARM pipeline encodings: EXE_CMD opcodes, condition codes and status flag bit positions.
package arm_pkg;

  localparam logic [3:0] CmdNop = 4'd0;
  localparam logic [3:0] CmdMov = 4'd1;
  localparam logic [3:0] CmdAdd = 4'd2;
  localparam logic [3:0] CmdAdc = 4'd3;
  localparam logic [3:0] CmdSub = 4'd4;
  localparam logic [3:0] CmdSbc = 4'd5;
  localparam logic [3:0] CmdAnd = 4'd6;
  localparam logic [3:0] CmdOrr = 4'd7;
  localparam logic [3:0] CmdEor = 4'd8;
  localparam logic [3:0] CmdMvn = 4'd9;

  localparam logic [3:0] CondEq = 4'h0;
  localparam logic [3:0] CondNe = 4'h1;
  localparam logic [3:0] CondCs = 4'h2;
  localparam logic [3:0] CondCc = 4'h3;
  localparam logic [3:0] CondMi = 4'h4;
  localparam logic [3:0] CondPl = 4'h5;
  localparam logic [3:0] CondVs = 4'h6;
  localparam logic [3:0] CondVc = 4'h7;
  localparam logic [3:0] CondHi = 4'h8;
  localparam logic [3:0] CondLs = 4'h9;
  localparam logic [3:0] CondGe = 4'hA;
  localparam logic [3:0] CondLt = 4'hB;
  localparam logic [3:0] CondGt = 4'hC;
  localparam logic [3:0] CondLe = 4'hD;
  localparam logic [3:0] CondAl = 4'hE;

  localparam int unsigned FlagN = 3;
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagV = 0;

  // Only data-processing opcodes MOV..MVN are allowed to update the status register.
  function automatic logic cmd_sets_flags(input logic [3:0] cmd);
    return (cmd >= CmdMov) && (cmd <= CmdMvn);
  endfunction

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition-field evaluator over a {N,Z,C,V} flag vector.
module cond_check
  import arm_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       pass_o
);

  logic n, z, c, v;

  assign n = flags_i[FlagN];
  assign z = flags_i[FlagZ];
  assign c = flags_i[FlagC];
  assign v = flags_i[FlagV];

  always_comb begin
    pass_o = 1'b0;
    unique case (cond_i)
      CondEq:  pass_o = z;
      CondNe:  pass_o = ~z;
      CondCs:  pass_o = c;
      CondCc:  pass_o = ~c;
      CondMi:  pass_o = n;
      CondPl:  pass_o = ~n;
      CondVs:  pass_o = v;
      CondVc:  pass_o = ~v;
      CondHi:  pass_o = c & ~z;
      CondLs:  pass_o = ~c | z;
      CondGe:  pass_o = (n == v);
      CondLt:  pass_o = (n != v);
      CondGt:  pass_o = ~z & (n == v);
      CondLe:  pass_o = z | (n != v);
      CondAl:  pass_o = 1'b1;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/status_cond_unit.sv
// EX-stage N/Z/C/V status register with an ID-stage condition evaluator that sees in-flight updates.
module status_cond_unit
  import arm_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       freeze_i,
  input  logic       flush_i,
  input  logic       ex_valid_i,
  input  logic       ex_s_i,
  input  logic [3:0] ex_cmd_i,
  input  logic [3:0] alu_status_i,
  input  logic       shift_carry_i,
  input  logic       id_valid_i,
  input  logic [3:0] id_cond_i,
  output logic [3:0] flags_o,
  output logic       alu_carry_o,
  output logic       cond_pass_o,
  output logic       cond_pass_q_o
);

  logic [3:0] sr_q, sr_d;
  logic [3:0] nf, eff;
  logic       wr, eval_pass, cond_pass_d, cond_pass_q;

  // alu_status[2] is "result nonzero", so Z is its inverse.
  always_comb begin
    nf = sr_q;
    unique case (ex_cmd_i)
      CmdAdd, CmdAdc, CmdSub, CmdSbc:
        nf = {alu_status_i[3], ~alu_status_i[2], alu_status_i[1], alu_status_i[0]};
      CmdMov, CmdAnd, CmdOrr, CmdEor, CmdMvn:
        nf = {alu_status_i[3], ~alu_status_i[2], shift_carry_i, sr_q[FlagV]};
      default: nf = sr_q;
    endcase
  end

  assign wr  = ex_valid_i & ex_s_i & cmd_sets_flags(ex_cmd_i);
  // Bypass ignores freeze: a stalled setter still owns the youngest flags.
  assign eff = wr ? nf : sr_q;

  cond_check u_cond_check (
    .cond_i  (id_cond_i),
    .flags_i (eff),
    .pass_o  (eval_pass)
  );

  assign cond_pass_o = id_valid_i & eval_pass;

  always_comb begin
    sr_d = sr_q;
    if (wr && !freeze_i) sr_d = nf;
  end

  always_comb begin
    cond_pass_d = cond_pass_o;
    if (flush_i)       cond_pass_d = 1'b0;
    else if (freeze_i) cond_pass_d = cond_pass_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sr_q        <= 4'b0000;
      cond_pass_q <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      cond_pass_q <= cond_pass_d;
    end
  end

  assign flags_o       = sr_q;
  assign alu_carry_o   = sr_q[FlagC];
  assign cond_pass_q_o = cond_pass_q;

endmodule
